// File: rtl/prefix_adder_pipe_if.sv
// Operand/result bundle for prefix_adder_pipe.
// Handshake: a transfer happens on a rising edge where valid && ready are both 1.
// The sender holds its payload and valid steady until that edge, and ready never depends on valid.
interface prefix_adder_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [1:0]       op;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic             neg;

  modport master (
    output in_valid, A, B, op, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero, neg
  );

  modport slave (
    input  in_valid, A, B, op, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero, neg
  );
endinterface

// File: rtl/prefix_adder_pipe.sv
// Three-stage pipelined add/sub with a Kogge-Stone carry tree and a global stall.
// S1: per-bit P/G, S2: group P/G out of the prefix tree, S3: sum and flags.
module prefix_adder_pipe #(
  parameter int WIDTH = 32
) (
  input logic                clk,
  input logic                reset_n,
  prefix_adder_pipe_if.slave bus
);
  localparam int LEVELS = $clog2(WIDTH);

  if (WIDTH < 8 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("prefix_adder_pipe: WIDTH must be a power of two from 8 to 64");
  end

  // Returns {group_g, group_p}; bit i covers bits i..0 once every span is applied.
  function automatic logic [2*WIDTH-1:0] prefix_tree(input logic [WIDTH-1:0] g_in,
                                                     input logic [WIDTH-1:0] p_in);
    logic [WIDTH-1:0] g, p, g_nx, p_nx;
    g = g_in;
    p = p_in;
    for (int l = 0; l < LEVELS; l++) begin
      g_nx = g;
      p_nx = p;
      for (int i = (1 << l); i < WIDTH; i++) begin
        g_nx[i] = g[i] | (p[i] & g[i - (1 << l)]);
        p_nx[i] = p[i] & p[i - (1 << l)];
      end
      g = g_nx;
      p = p_nx;
    end
    return {g, p};
  endfunction

  logic             advance;
  logic             v1, v2, v3;
  logic [WIDTH-1:0] p1, g1;
  logic             c0_1, a_msb1, bx_msb1;
  logic [WIDTH-1:0] p2, gg2, pg2;
  logic             c0_2, a_msb2, bx_msb2;
  logic [WIDTH-1:0] sum3;
  logic             cout3, ovf3, zero3, neg3;

  logic [WIDTH-1:0] bx;
  logic             c0;
  logic [WIDTH-1:0] gg_nx, pg_nx;
  logic [WIDTH-1:0] carries;
  logic [WIDTH-1:0] sum_nx;
  logic             cout_nx;

  // op[0] selects subtraction; op[1] takes the carry from cin instead of op[0].
  assign bx = bus.op[0] ? ~bus.B : bus.B;
  assign c0 = bus.op[1] ? bus.cin : bus.op[0];

  assign {gg_nx, pg_nx} = prefix_tree(g1, p1);

  // Carry into bit i is the group generate of bits i-1..0 with c0 folded in.
  assign carries = {gg2[WIDTH-2:0] | (pg2[WIDTH-2:0] & {(WIDTH-1){c0_2}}), c0_2};
  assign sum_nx  = p2 ^ carries;
  assign cout_nx = gg2[WIDTH-1] | (pg2[WIDTH-1] & c0_2);

  assign advance      = !v3 || bus.out_ready;
  assign bus.in_ready = advance;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      v3      <= 1'b0;
      p1      <= '0;
      g1      <= '0;
      c0_1    <= 1'b0;
      a_msb1  <= 1'b0;
      bx_msb1 <= 1'b0;
      p2      <= '0;
      gg2     <= '0;
      pg2     <= '0;
      c0_2    <= 1'b0;
      a_msb2  <= 1'b0;
      bx_msb2 <= 1'b0;
      sum3    <= '0;
      cout3   <= 1'b0;
      ovf3    <= 1'b0;
      zero3   <= 1'b0;
      neg3    <= 1'b0;
    end else if (advance) begin
      v1      <= bus.in_valid;
      p1      <= bus.A ^ bx;
      g1      <= bus.A & bx;
      c0_1    <= c0;
      a_msb1  <= bus.A[WIDTH-1];
      bx_msb1 <= bx[WIDTH-1];

      v2      <= v1;
      p2      <= p1;
      gg2     <= gg_nx;
      pg2     <= pg_nx;
      c0_2    <= c0_1;
      a_msb2  <= a_msb1;
      bx_msb2 <= bx_msb1;

      v3      <= v2;
      sum3    <= sum_nx;
      cout3   <= cout_nx;
      ovf3    <= (a_msb2 == bx_msb2) && (sum_nx[WIDTH-1] != a_msb2);
      zero3   <= (sum_nx == '0);
      neg3    <= sum_nx[WIDTH-1];
    end
  end

  assign bus.out_valid = v3;
  assign bus.sum       = sum3;
  assign bus.cout      = cout3;
  assign bus.ovf       = ovf3;
  assign bus.zero      = zero3;
  assign bus.neg       = neg3;
endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Directed and random checks for prefix_adder_pipe (WIDTH=32) with an in-order scoreboard.
module tb_prefix_adder_pipe;
  localparam int W = 32;

  logic clk;
  logic reset_n;
  int   vectors;
  int   miscompares;
  int   cyc;
  int   beats;
  int   first_pop_cyc;
  int   last_pop_cyc;
  logic [W+3:0] exp_q[$];

  prefix_adder_pipe_if #(.WIDTH(W)) bus ();

  prefix_adder_pipe #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Packed as {neg, zero, ovf, cout, sum}.
  function automatic logic [W+3:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic cin);
    logic [W-1:0] bxm;
    logic         c0m;
    logic [W:0]   full;
    logic [W-1:0] s;
    logic         ov;
    bxm  = op[0] ? ~b : b;
    c0m  = op[1] ? cin : op[0];
    full = {1'b0, a} + {1'b0, bxm} + {{W{1'b0}}, c0m};
    s    = full[W-1:0];
    ov   = (a[W-1] == bxm[W-1]) && (s[W-1] != a[W-1]);
    return {s[W-1], s == '0, ov, full[W], s};
  endfunction

  function automatic logic [W+3:0] observed();
    return {bus.neg, bus.zero, bus.ovf, bus.cout, bus.sum};
  endfunction

  // Scoreboard: every result the DUT hands over is matched against the oldest expectation.
  always @(negedge clk) begin
    if (reset_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 64'(observed()), 64'hDEAD);
      end else begin
        check("result", 64'(observed()), 64'(exp_q.pop_front()));
      end
      if (beats == 0) first_pop_cyc = cyc;
      last_pop_cyc = cyc;
      beats++;
    end
  end

  // Waits for acceptance, then records the expected result.
  task automatic send_exp(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic [W+3:0] exp);
    int n;
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.A        = a;
    bus.B        = b;
    bus.cin      = cin;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) check("accept_timeout", 64'(bus.in_ready), 64'd1);
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin);
    send_exp(op, a, b, cin, model(op, a, b, cin));
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    cyc           = 0;
    beats         = 0;
    first_pop_cyc = 0;
    last_pop_cyc  = 0;
    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.op        = 2'b00;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_outputs", 64'(observed()), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // ADD wrap with exact latency: first accept on the first edge after release.
    send_exp(2'b00, 32'hFFFF_FFFF, 32'h1, 1'b0, 36'h5_0000_0000);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("lat_edge1", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    check("lat_edge2", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    check("lat_edge3", 64'(bus.out_valid), 64'd1);
    wait_drain();

    send_exp(2'b01, 32'h8000_0000, 32'h1, 1'b0, 36'h3_7FFF_FFFF);
    send_exp(2'b10, 32'h7FFF_FFFF, 32'h0, 1'b1, 36'hA_8000_0000);
    send_exp(2'b11, 32'h5, 32'h5, 1'b0, 36'h8_FFFF_FFFF);
    send_exp(2'b11, 32'h5, 32'h5, 1'b1, 36'h5_0000_0000);
    send_exp(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 36'h9_FFFF_FFFF);
    bus.in_valid = 1'b0;
    wait_drain();

    // Eight back-to-back random operations must leave on eight consecutive cycles.
    beats = 0;
    for (int i = 0; i < 8; i++) begin
      send(2'($urandom_range(3, 0)), $urandom, $urandom, 1'($urandom_range(1, 0)));
    end
    bus.in_valid = 1'b0;
    wait_drain();
    check("stream_beats", 64'(beats), 64'd8);
    check("stream_span", 64'(last_pop_cyc - first_pop_cyc), 64'd7);

    // Fill with out_ready low, stall five cycles, then release while accepting a fourth op.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(2'($urandom_range(3, 0)), $urandom, $urandom, 1'($urandom_range(1, 0)));
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.A = $urandom;
      bus.B = $urandom;
      @(negedge clk);
      check("stall_in_ready", 64'(bus.in_ready), 64'd0);
      check("stall_out_valid", 64'(bus.out_valid), 64'd1);
      check("stall_frozen", 64'(observed()), 64'(exp_q[0]));
      @(posedge clk);
      #1;
    end
    beats = 0;
    bus.out_ready = 1'b1;
    send(2'b01, 32'h1234_5678, 32'h8765_4321, 1'b0);
    bus.in_valid = 1'b0;
    wait_drain();
    check("stall_drain_beats", 64'(beats), 64'd4);

    // Reset with two operations in flight: nothing may come out afterwards.
    send(2'b00, 32'h1111_1111, 32'h2222_2222, 1'b0);
    send(2'b00, 32'h3333_3333, 32'h4444_4444, 1'b0);
    bus.in_valid = 1'b0;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    check("midrst_outputs", 64'(observed()), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    beats = 0;
    repeat (6) begin
      @(negedge clk);
      check("postrst_no_stale", 64'(bus.out_valid), 64'd0);
    end
    check("postrst_beats", 64'(beats), 64'd0);

    @(posedge clk);
    #1;
    send(2'b00, 32'hCAFE_0000, 32'h0000_BABE, 1'b0);
    bus.in_valid = 1'b0;
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
